// File: rtl/ob_pkg.sv
// Shared order-book types: response word layout and the egress serializer state set.
package ob_pkg;

  typedef struct packed {
    logic [7:0]  status;
    logic [15:0] order_id;
    logic [23:0] qty;
  } rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    PAY  = 2'd2,
    CSUM = 2'd3
  } tx_state_t;

  localparam int OB_TX_LEN_W = 8;

  // Running frame checksum: fold one more byte into the XOR accumulator.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/ob_rsp_tx.sv
// Egress serializer: frames one response as LEN, payload bytes MSB-first and
// an optional XOR trailer on a byte-wide valid/accept link.
module ob_rsp_tx
  import ob_pkg::*;
#(
  parameter int RSP_W   = $bits(rsp_t),
  parameter bit CSUM_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rsp_vld,
  input  logic [RSP_W-1:0] rsp,
  output logic             rsp_accept,
  output logic             tx_vld_r,
  output logic [7:0]       tx_data_r,
  output logic             tx_sop_r,
  output logic             tx_eop_r,
  input  logic             tx_accept,
  output logic             busy_r,
  output logic [31:0]      pkt_cnt_r
);

  localparam int N    = (RSP_W + 7) / 8;
  localparam int SH_W = 8 * N;
  localparam logic [OB_TX_LEN_W-1:0] LEN_BYTE = OB_TX_LEN_W'(N);
  localparam logic [7:0]             LAST_IDX = 8'(N - 1);

  tx_state_t       state_r;
  logic [SH_W-1:0] shift_r;
  logic [7:0]      idx_r;
  logic [7:0]      csum_r;
  logic            hs_s;
  logic            accept_s;
  logic [7:0]      pay_byte_s;

  // Handshake decode; a new response is taken when idle or as the current EOP leaves
  always_comb begin
    hs_s       = tx_vld_r & tx_accept;
    pay_byte_s = shift_r[SH_W-1 -: 8];
    if (rst) begin
      accept_s = 1'b0;
    end else begin
      accept_s = rsp_vld & ((state_r == IDLE) | (tx_eop_r & hs_s));
    end
  end

  assign rsp_accept = accept_s;

  // Frame sequencer: loads the next byte into the output register on each handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      idx_r     <= 8'd0;
      csum_r    <= 8'd0;
      tx_vld_r  <= 1'b0;
      tx_data_r <= 8'd0;
      tx_sop_r  <= 1'b0;
      tx_eop_r  <= 1'b0;
      busy_r    <= 1'b0;
      pkt_cnt_r <= 32'd0;
    end else begin
      if (hs_s && tx_eop_r) begin
        pkt_cnt_r <= pkt_cnt_r + 32'd1;
      end
      if (accept_s) begin
        state_r   <= LEN;
        shift_r   <= SH_W'(rsp);
        idx_r     <= 8'd0;
        csum_r    <= csum_fold(8'd0, LEN_BYTE);
        tx_vld_r  <= 1'b1;
        tx_data_r <= LEN_BYTE;
        tx_sop_r  <= 1'b1;
        tx_eop_r  <= 1'b0;
        busy_r    <= 1'b1;
      end else if (hs_s && tx_eop_r) begin
        state_r  <= IDLE;
        tx_vld_r <= 1'b0;
        tx_sop_r <= 1'b0;
        tx_eop_r <= 1'b0;
        busy_r   <= 1'b0;
      end else if (hs_s) begin
        case (state_r)
          LEN: begin
            state_r   <= PAY;
            idx_r     <= 8'd0;
            tx_data_r <= pay_byte_s;
            csum_r    <= csum_fold(csum_r, pay_byte_s);
            shift_r   <= shift_r << 8;
            tx_sop_r  <= 1'b0;
            tx_eop_r  <= (LAST_IDX == 8'd0) && !CSUM_EN;
          end
          PAY: begin
            // Without a trailer the last payload byte carries EOP and exits above
            if (CSUM_EN && (idx_r == LAST_IDX)) begin
              state_r   <= CSUM;
              tx_data_r <= csum_r;
              tx_eop_r  <= 1'b1;
            end else begin
              idx_r     <= idx_r + 8'd1;
              tx_data_r <= pay_byte_s;
              csum_r    <= csum_fold(csum_r, pay_byte_s);
              shift_r   <= shift_r << 8;
              tx_eop_r  <= ((idx_r + 8'd1) == LAST_IDX) && !CSUM_EN;
            end
          end
          default: begin
            state_r <= state_r;
          end
        endcase
      end
    end
  end

endmodule
